// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and constants for the CNN accelerator datapath.
//   word_t  - one IEEE-754 single-precision bit pattern
//   N/M/K/R/C - default layer dimensions (in-ch, out-ch, kernel, rows, cols)
//   state_t - output feature map writer control states
//   cw()    - counter width helper that never returns zero
package cnn_pkg;
    localparam int W_P = 32;
    typedef logic [W_P-1:0] word_t;

    localparam int N = 8;
    localparam int M = 4;
    localparam int K = 3;
    localparam int R = 16;
    localparam int C = 16;

    typedef enum logic {FILL, DRAIN} state_t;

    // A dimension of 1 still needs a 1-bit counter.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ofm_writer_if.sv
// ofm_writer_if: pixel-beat input stream and word output stream of the
// output feature map writer. Signal names carry the writer's view (_i into
// the writer, _o out of it).
//   slave  - writer side
//   master - compute array / sink side (testbench)
interface ofm_writer_if #(
    parameter int M_P = 4,
    parameter int W_P = 32
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic [M_P-1:0][W_P-1:0]   in_data_i;   // lane m = channel m
    logic                      out_valid_o;
    logic                      out_ready_i;
    logic [W_P-1:0]            out_data_o;
    logic                      out_last_o;
    logic                      frame_done_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, frame_done_o
    );
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, frame_done_o
    );
endinterface

// File: rtl/ofm_bank_ram.sv
// ofm_bank_ram: simple dual-port RAM, one write port and one read port with
// a 1-cycle synchronous read. The read register only updates when re_i is
// high, so a read result holds until the next read is issued.
//   clk_i             - clock
//   we_i/waddr_i/wdata_i - write port
//   re_i/raddr_i      - read port request
//   rdata_o           - registered read data
module ofm_bank_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/ofm_writer.sv
// ofm_writer: collects one pixel position (M_P channels) per input beat into
// M_P banks, then streams the full frame out one word at a time in
// channel-major [m][r][c] order.
//   clk_i, rst_n_i - clock, asynchronous active-low reset
//   bus (slave)    - in_valid/in_ready/in_data pixel beats;
//                    out_valid/out_ready/out_data/out_last words;
//                    frame_done one-cycle pulse after the final word.
module ofm_writer
    import cnn_pkg::*;
#(
    parameter int M_P = M,
    parameter int R_P = R,
    parameter int C_P = C
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    ofm_writer_if.slave bus
);
    localparam int MW    = cw(M_P);
    localparam int RW    = cw(R_P);
    localparam int CW    = cw(C_P);
    localparam int DEPTH = R_P * C_P;
    localparam int AW    = cw(DEPTH);

    state_t          state_q, state_d;
    logic [RW-1:0]   wr_r_q, wr_r_d;
    logic [CW-1:0]   wr_c_q, wr_c_d;
    logic [MW-1:0]   rd_m_q, rd_m_d;
    logic [RW-1:0]   rd_r_q, rd_r_d;
    logic [CW-1:0]   rd_c_q, rd_c_d;
    logic            iss_done_q, iss_done_d;   // every read of the frame issued
    logic            rv_q, rv_d;               // RAM read register holds a live word
    logic [MW-1:0]   rsel_q, rsel_d;           // bank of the word in the read register
    logic            rlast_q, rlast_d;
    logic            sk_vld_q, sk_vld_d;
    word_t           sk_data_q, sk_data_d;
    logic            sk_last_q, sk_last_d;
    logic            done_q, done_d;

    logic [M_P-1:0][W_P-1:0] bank_q;
    logic [AW-1:0]   waddr, raddr;
    logic            in_fire, issue, rd_last;
    logic            out_vld, out_fire, out_lst, frame_end;
    word_t           ram_word, out_word;

    assign in_fire  = bus.in_valid_i && (state_q == FILL);
    assign waddr    = AW'(wr_r_q) * AW'(C_P) + AW'(wr_c_q);
    assign raddr    = AW'(rd_r_q) * AW'(C_P) + AW'(rd_c_q);

    // A new read would overwrite the read register, so it is only issued
    // while the skid is free to catch a word that is not leaving this cycle.
    assign issue    = (state_q == DRAIN) && !iss_done_q && !sk_vld_q;
    assign rd_last  = (rd_m_q == MW'(M_P-1)) && (rd_r_q == RW'(R_P-1)) &&
                      (rd_c_q == CW'(C_P-1));

    assign ram_word = bank_q[rsel_q];
    // The skid always holds the older word, so it is presented first.
    assign out_vld  = sk_vld_q || rv_q;
    assign out_word = sk_vld_q ? sk_data_q : ram_word;
    assign out_lst  = sk_vld_q ? sk_last_q : rlast_q;
    assign out_fire = out_vld && bus.out_ready_i;
    assign frame_end = out_fire && out_lst;

    for (genvar g = 0; g < M_P; g++) begin : g_bank
        ofm_bank_ram #(.DEPTH(DEPTH), .AW(AW), .W(W_P)) u_bank (
            .clk_i   (clk_i),
            .we_i    (in_fire),
            .waddr_i (waddr),
            .wdata_i (bus.in_data_i[g]),
            .re_i    (issue),
            .raddr_i (raddr),
            .rdata_o (bank_q[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        wr_r_d     = wr_r_q;
        wr_c_d     = wr_c_q;
        rd_m_d     = rd_m_q;
        rd_r_d     = rd_r_q;
        rd_c_d     = rd_c_q;
        iss_done_d = iss_done_q;
        rv_d       = rv_q;
        rsel_d     = rsel_q;
        rlast_d    = rlast_q;
        sk_vld_d   = sk_vld_q;
        sk_data_d  = sk_data_q;
        sk_last_d  = sk_last_q;
        done_d     = 1'b0;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    if (wr_c_q == CW'(C_P-1)) begin
                        wr_c_d = '0;
                        if (wr_r_q == RW'(R_P-1)) begin
                            wr_r_d  = '0;
                            state_d = DRAIN;
                        end else begin
                            wr_r_d = wr_r_q + 1'b1;
                        end
                    end else begin
                        wr_c_d = wr_c_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (issue) begin
                    rsel_d  = rd_m_q;
                    rlast_d = rd_last;
                    if (rd_last) iss_done_d = 1'b1;
                    if (rd_c_q == CW'(C_P-1)) begin
                        rd_c_d = '0;
                        if (rd_r_q == RW'(R_P-1)) begin
                            rd_r_d = '0;
                            rd_m_d = (rd_m_q == MW'(M_P-1)) ? '0 : rd_m_q + 1'b1;
                        end else begin
                            rd_r_d = rd_r_q + 1'b1;
                        end
                    end else begin
                        rd_c_d = rd_c_q + 1'b1;
                    end
                end
                // Read register word stalls while a new read lands: park it.
                if (sk_vld_q) begin
                    if (out_fire) sk_vld_d = 1'b0;
                end else if (issue && rv_q && !out_fire) begin
                    sk_vld_d  = 1'b1;
                    sk_data_d = ram_word;
                    sk_last_d = rlast_q;
                end
                rv_d = issue ? 1'b1 : (rv_q && !(out_fire && !sk_vld_q));
                if (frame_end) begin
                    state_d    = FILL;
                    rd_m_d     = '0;
                    rd_r_d     = '0;
                    rd_c_d     = '0;
                    iss_done_d = 1'b0;
                    rv_d       = 1'b0;
                    sk_vld_d   = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= FILL;
            wr_r_q     <= '0;
            wr_c_q     <= '0;
            rd_m_q     <= '0;
            rd_r_q     <= '0;
            rd_c_q     <= '0;
            iss_done_q <= 1'b0;
            rv_q       <= 1'b0;
            rsel_q     <= '0;
            rlast_q    <= 1'b0;
            sk_vld_q   <= 1'b0;
            sk_data_q  <= '0;
            sk_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_r_q     <= wr_r_d;
            wr_c_q     <= wr_c_d;
            rd_m_q     <= rd_m_d;
            rd_r_q     <= rd_r_d;
            rd_c_q     <= rd_c_d;
            iss_done_q <= iss_done_d;
            rv_q       <= rv_d;
            rsel_q     <= rsel_d;
            rlast_q    <= rlast_d;
            sk_vld_q   <= sk_vld_d;
            sk_data_q  <= sk_data_d;
            sk_last_q  <= sk_last_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready_o   = (state_q == FILL);
    assign bus.out_valid_o  = out_vld;
    // RAM output is not reset; mask it so idle data reads as zero.
    assign bus.out_data_o   = out_vld ? out_word : '0;
    assign bus.out_last_o   = out_vld && out_lst;
    assign bus.frame_done_o = done_q;
endmodule

// File: tb/tb_ofm_writer.sv
module tb_ofm_writer;
    localparam int M  = 4;
    localparam int R  = 16;
    localparam int C  = 16;
    localparam int W  = 32;
    localparam int RC = R * C;
    localparam int FW = M * RC;

    typedef logic [M-1:0][W-1:0] beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ofm_writer_if #(.M_P(M), .W_P(W)) bus();
    ofm_writer #(.M_P(M), .R_P(R), .C_P(C)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: beats still to send, words expected out.
    beat_t        stim_q[$];
    logic [W-1:0] exp_q[$];
    // Observations of one run.
    logic [W-1:0] got_d[$];
    logic         got_l[$];
    int           xfer_cyc[$], acc_cyc[$], done_cyc[$], fv_cyc[$];
    logic         ir_hist[$];
    int           stall_err;
    bit           timeout;

    // A frame is R*C beats of M lanes; it leaves as channel-major words:
    // word m*RC + p is lane m of beat p.
    task automatic build_frame(input bit rnd);
        beat_t fr[RC];
        for (int p = 0; p < RC; p++) begin
            for (int m = 0; m < M; m++)
                fr[p][m] = rnd ? $urandom() : {8'h00, 8'(m), 8'(p / C), 8'(p % C)};
            stim_q.push_back(fr[p]);
        end
        for (int m = 0; m < M; m++)
            for (int p = 0; p < RC; p++)
                exp_q.push_back(fr[p][m]);
    endtask

    // Drives beats and ready once per cycle at the falling edge, records what
    // the DUT shows and which handshakes the next rising edge will complete.
    task automatic run(input bit gap, input bit bp, input int stop_beats,
                       input int stop_words, input int budget);
        int           n = 0;
        int           nacc = 0;
        logic         pv = 1'b0, pstall = 1'b0, pl = 1'b0;
        logic [W-1:0] pd = '0;
        logic         ir, ov, ol, vin, rdy;
        logic [W-1:0] od;
        got_d.delete(); got_l.delete(); xfer_cyc.delete(); acc_cyc.delete();
        done_cyc.delete(); fv_cyc.delete(); ir_hist.delete();
        stall_err = 0;
        timeout   = 1'b1;
        while (n < budget) begin
            @(negedge clk);
            ir = bus.in_ready_o;
            ov = bus.out_valid_o;
            od = bus.out_data_o;
            ol = bus.out_last_o;
            ir_hist.push_back(ir);
            if (bus.frame_done_o) done_cyc.push_back(n);
            if (ov && !pv) fv_cyc.push_back(n);
            if (pstall && (!ov || od !== pd || ol !== pl)) stall_err++;
            vin = (stim_q.size() > 0) && (!gap || (n % 2 == 0));
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid_i  = vin;
            bus.in_data_i   = vin ? stim_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.out_ready_i = rdy;
            if (vin && ir) begin
                void'(stim_q.pop_front());
                acc_cyc.push_back(n);
                nacc++;
            end
            if (ov && rdy) begin
                got_d.push_back(od);
                got_l.push_back(ol);
                xfer_cyc.push_back(n);
            end
            pstall = ov && !rdy;
            pv = ov; pd = od; pl = ol;
            n++;
            if ((stop_beats > 0 && nacc == stop_beats) ||
                (stop_words > 0 && got_d.size() == stop_words) ||
                (stop_beats == 0 && stop_words == 0 && stim_q.size() == 0 &&
                 done_cyc.size() == exp_q.size() / FW)) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        #2;
        checks += 5;
        if (bus.in_ready_o !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        if (bus.out_data_o !== '0)    begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data_o); end
        if (bus.out_last_o !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last_o); end
        if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int t, d, bad;
        stim_q.delete(); exp_q.delete();
        build_frame(1'b0);
        run(1'b0, 1'b0, 0, 0, 3000);
        checks++;
        if (timeout) begin errors++; $display("FAIL basic_timeout: frame did not complete"); end
        checks++;
        if (got_d.size() != FW) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_d.size(), FW); end
        for (int i = 0; i < got_d.size() && i < FW; i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == FW - 1)) begin
                errors++;
                $display("FAIL basic_word[%0d]: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_q[i], i == FW - 1);
            end
        end
        if (got_d.size() == FW && done_cyc.size() == 1 && acc_cyc.size() == RC && fv_cyc.size() >= 1) begin
            t = acc_cyc[RC-1];
            d = xfer_cyc[FW-1];
            checks += 5;
            if (done_cyc[0] != d + 1) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc[0], d + 1); end
            if (fv_cyc[0] != t + 2) begin errors++; $display("FAIL latency_first_valid: got %0d want %0d", fv_cyc[0], t + 2); end
            if (d - xfer_cyc[0] != FW - 1) begin errors++; $display("FAIL basic_throughput: got %0d want %0d", d - xfer_cyc[0], FW - 1); end
            bad = 0;
            for (int k = t + 1; k <= d; k++) if (ir_hist[k] !== 1'b0) bad++;
            if (bad != 0) begin errors++; $display("FAIL latency_in_ready_drain: got %0d high cycles want 0", bad); end
            if (ir_hist[d+1] !== 1'b1) begin errors++; $display("FAIL basic_in_ready_after_done: got %b want 1", ir_hist[d+1]); end
        end else begin
            checks++; errors++;
            $display("FAIL basic_timing_records: done %0d acc %0d fv %0d", done_cyc.size(), acc_cyc.size(), fv_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        stim_q.delete(); exp_q.delete();
        build_frame(1'b1);
        run(1'b0, 1'b1, 0, 0, 8000);
        checks += 3;
        if (timeout) begin errors++; $display("FAIL bp_timeout: frame did not complete"); end
        if (got_d.size() != FW) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_d.size(), FW); end
        if (stall_err != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_err); end
        for (int i = 0; i < got_d.size() && i < FW; i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == FW - 1)) begin
                errors++;
                $display("FAIL bp_word[%0d]: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_q[i], i == FW - 1);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || xfer_cyc.size() == 0 || done_cyc[0] != xfer_cyc[xfer_cyc.size()-1] + 1) begin
            errors++; $display("FAIL bp_done_pulse: got %0d pulses want 1 after final word", done_cyc.size());
        end
    endtask

    task automatic test_gaps();
        stim_q.delete(); exp_q.delete();
        build_frame(1'b0);
        run(1'b1, 1'b0, 0, 0, 3000);
        checks += 2;
        if (timeout) begin errors++; $display("FAIL gaps_timeout: frame did not complete"); end
        if (got_d.size() != FW) begin errors++; $display("FAIL gaps_count: got %0d want %0d", got_d.size(), FW); end
        for (int i = 0; i < got_d.size() && i < FW; i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == FW - 1)) begin
                errors++;
                $display("FAIL gaps_word[%0d]: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_q[i], i == FW - 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int ph = 0; ph < 2; ph++) begin
            stim_q.delete(); exp_q.delete();
            build_frame(1'b1);
            if (ph == 0) run(1'b0, 1'b0, 100, 0, 1000);
            else         run(1'b0, 1'b1, 0, 300, 3000);
            checks++;
            if (timeout) begin errors++; $display("FAIL rmid_reach_point[%0d]: stop point not reached", ph); end
            if (ph == 1) begin
                for (int i = 0; i < got_d.size(); i++) begin
                    checks++;
                    if (got_d[i] !== exp_q[i]) begin
                        errors++; $display("FAIL rmid_partial_word[%0d]: got %h want %h", i, got_d[i], exp_q[i]);
                    end
                end
            end
            rst_n = 1'b0;
            #1;
            checks += 5;
            if (bus.in_ready_o !== 1'b1)   begin errors++; $display("FAIL rmid_in_ready[%0d]: got %b want 1", ph, bus.in_ready_o); end
            if (bus.out_valid_o !== 1'b0)  begin errors++; $display("FAIL rmid_out_valid[%0d]: got %b want 0", ph, bus.out_valid_o); end
            if (bus.out_data_o !== '0)     begin errors++; $display("FAIL rmid_out_data[%0d]: got %h want 0", ph, bus.out_data_o); end
            if (bus.out_last_o !== 1'b0)   begin errors++; $display("FAIL rmid_out_last[%0d]: got %b want 0", ph, bus.out_last_o); end
            if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL rmid_frame_done[%0d]: got %b want 0", ph, bus.frame_done_o); end
            bus.in_valid_i  = 1'b0;
            bus.out_ready_i = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        stim_q.delete(); exp_q.delete();
        build_frame(1'b1);
        run(1'b0, 1'b0, 0, 0, 3000);
        checks += 2;
        if (timeout) begin errors++; $display("FAIL rmid_after_timeout: frame did not complete"); end
        if (got_d.size() != FW) begin errors++; $display("FAIL rmid_after_count: got %0d want %0d", got_d.size(), FW); end
        for (int i = 0; i < got_d.size() && i < FW; i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i == FW - 1)) begin
                errors++;
                $display("FAIL rmid_after_word[%0d]: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_q[i], i == FW - 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_q.delete(); exp_q.delete();
        build_frame(1'b0);
        build_frame(1'b1);
        run(1'b0, 1'b0, 0, 0, 6000);
        checks += 2;
        if (timeout) begin errors++; $display("FAIL b2b_timeout: frames did not complete"); end
        if (got_d.size() != 2 * FW) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_d.size(), 2 * FW); end
        for (int i = 0; i < got_d.size() && i < 2 * FW; i++) begin
            checks++;
            if (got_d[i] !== exp_q[i] || got_l[i] !== (i % FW == FW - 1)) begin
                errors++;
                $display("FAIL b2b_word[%0d]: got %h last %b want %h last %b", i, got_d[i], got_l[i], exp_q[i], i % FW == FW - 1);
            end
        end
        checks++;
        if (done_cyc.size() == 2 && acc_cyc.size() == 2 * RC && fv_cyc.size() == 2) begin
            if (acc_cyc[RC] != done_cyc[0]) begin
                errors++; $display("FAIL b2b_second_accept: got cycle %0d want %0d", acc_cyc[RC], done_cyc[0]);
            end
            checks++;
            if (fv_cyc[1] != acc_cyc[2*RC-1] + 2) begin
                errors++; $display("FAIL b2b_second_latency: got %0d want %0d", fv_cyc[1], acc_cyc[2*RC-1] + 2);
            end
        end else begin
            errors++;
            $display("FAIL b2b_records: done %0d acc %0d fv %0d", done_cyc.size(), acc_cyc.size(), fv_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ofm_writer.md
# ofm_writer

Output feature map writer for the CNN accelerator. Collects convolution results from the compute array, one pixel position (all M_p output channels in parallel) per beat, into an on-chip buffer. Once a full frame is held, it streams the frame out as single 32-bit words in channel-major [m][r][c] order, the same flat order the output_fm test vectors use. It sits between the compute array and the host/testbench sink and is the write-side counterpart of the feature-map/weight loader.

## Interface
- M_p, 4, output channels (parallel lanes on input)
- R_p, 16, output rows
- C_p, 16, output columns
- W_p, 32, word width (IEEE-754 single-precision bit pattern)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  pixel beat valid
- in_ready_o  out  1  writer can accept a pixel beat
- in_data_i  in  M_p*W_p  lane m at bits [m*W_p +: W_p] = channel m result for current (r,c)
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  sink accepts word
- out_data_o  out  W_p  output word
- out_last_o  out  1  marks final word of frame (m=M_p-1, r=R_p-1, c=C_p-1)
- frame_done_o  out  1  one-cycle pulse after final word handshake

## Operation
- Input beats arrive in raster order: c fastest, then r. Beat k maps to r=k/C_p, c=k%C_p; no address is carried on the interface.
- States:
  - FILL (reset state): in_ready_o=1. Each in_valid_i&in_ready_o handshake writes all M_p lanes to buffer address r*C_p+c in bank m, then advances (c,r). On the handshake at r=R_p-1, c=C_p-1, go to DRAIN.
  - DRAIN: in_ready_o=0. Reads proceed in order m, then r, then c (c fastest), for M_p*R_p*C_p words total. When the word with out_last_o is handshaken, pulse frame_done_o on the next cycle, clear all counters, and return to FILL.
- Output handshake: a word transfers when out_valid_o&out_ready_i. While out_ready_i=0, out_data_o and out_last_o hold stable and out_valid_o stays high; out_valid_o never drops without a transfer.
- Counter widths: $clog2 of each dimension; the address is $clog2(R_p*C_p). Counters wrap exactly at their bound, never at a power of two.
- Reset (asynchronous, any state): state returns to FILL, all counters go to 0, and the output pipeline empties. Buffer contents are not cleared, and a partial frame is discarded.
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_last_o=0, frame_done_o=0.

## Timing
- Buffer read latency is 1 cycle (synchronous RAM).
- If the last input beat is accepted in cycle T, the state is DRAIN in T+1 and the first out_valid_o is asserted in T+2.
- With out_ready_i held high, throughput is 1 word/cycle with no bubbles. A frame drains in M_p*R_p*C_p cycles after the first valid.
- Backpressure: a prefetch register plus a 1-entry skid ensures that an out_ready_i deassertion causes no lost or duplicated word. When ready reasserts, the next word follows the held one on consecutive cycles.
- If the final handshake is in cycle D, frame_done_o=1 in D+1 and in_ready_o=1 in D+1.
- in_valid_i is ignored during DRAIN. out_ready_i is ignored during FILL.

## Configuration
- OFM_WRITER_DUMP_EN
  - Defined: simulation-only logic opens the file named by plusarg +ofm_dump=<path> (default "output_fm_dut.dat"). It writes each transferred word as one W_p-bit binary line, in the format $readmemb can read, and closes the file on frame_done_o. This lets the bench diff the file against the output_fm golden vectors.
  - Undefined: no file I/O; the RTL is fully synthesizable.

## Structure
- cnn_pkg holds:
  - the word typedef (logic [31:0]) and W_p;
  - default dimension constants N/M/K/R/C;
  - the state enum {FILL, DRAIN}.
- Sub-module ofm_bank_ram: simple dual-port, R_p*C_p x W_p, 1-cycle synchronous read. M_p instances, all sharing the write address.
- The read mux selects the bank using the m counter.

## Test plan
- Basic frame, ready always high:
  - Stimulus: M=4, R=C=16; lane m of beat (r,c) = {8'h0, m[7:0], r[7:0], c[7:0]}; 256 beats.
  - Expected: 1024 words in order 0x00000000, 0x00000001 … 0x00030F0F. out_last_o only on 0x00030F0F. frame_done_o one cycle later.
- Latency:
  - Stimulus: last beat accepted at cycle T.
  - Expected: first out_valid_o at T+2; in_ready_o=0 from T+1 until done.
- Backpressure:
  - Stimulus: out_ready_i random at 50% duty.
  - Expected: identical 1024-word sequence. out_data_o is stable across every stalled cycle, with no drops or duplicates.
- Input gaps:
  - Stimulus: in_valid_i toggles on alternate cycles.
  - Expected: the same buffer contents and output as the basic frame test.
- Reset mid-operation:
  - Stimulus: assert rst_n_i low during FILL after 100 beats, then again during DRAIN after 300 words.
  - Expected: outputs take their reset values immediately. The next full frame (new values) drains correctly with no stale words.
- Back-to-back frames:
  - Stimulus: two frames with distinct data, input offered continuously.
  - Expected: second-frame input is accepted from D+1. Both outputs are correct, and with OFM_WRITER_DUMP_EN defined the dump file matches the golden vectors.
